// File: rtl/pio_pkg.sv
// pio_pkg: register offsets, AXI response codes and the register-select decoder shared by
// the programmable I/O block.
package pio_pkg;

    // Byte offsets; only addr[7:2] takes part in the decode.
    localparam logic [7:0] ADDR_ODATA     = 8'h00;
    localparam logic [7:0] ADDR_OENABLE   = 8'h04;
    localparam logic [7:0] ADDR_IDATA     = 8'h08;
    localparam logic [7:0] ADDR_RISE_IE   = 8'h0C;
    localparam logic [7:0] ADDR_FALL_IE   = 8'h10;
    localparam logic [7:0] ADDR_RISE_PEND = 8'h14;
    localparam logic [7:0] ADDR_FALL_PEND = 8'h18;
    localparam logic [7:0] ADDR_ODATA_SET = 8'h1C;
    localparam logic [7:0] ADDR_ODATA_CLR = 8'h20;
    localparam logic [7:0] ADDR_ODATA_TOG = 8'h24;
    localparam logic [7:0] ADDR_INFO      = 8'h28;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [3:0] {
        SelNone,
        SelOdata,
        SelOenable,
        SelIdata,
        SelRiseIe,
        SelFallIe,
        SelRisePend,
        SelFallPend,
        SelOdataSet,
        SelOdataClr,
        SelOdataTog,
        SelInfo
    } reg_sel_e;

    // Map a word index (addr[7:2]) to a register select; the set/clr/tog aliases only
    // exist when the feature is built in.
    function automatic reg_sel_e decode_addr(input logic [5:0] widx, input logic setclr_en);
        reg_sel_e sel;
        sel = SelNone;
        case ({widx, 2'b00})
            ADDR_ODATA:     sel = SelOdata;
            ADDR_OENABLE:   sel = SelOenable;
            ADDR_IDATA:     sel = SelIdata;
            ADDR_RISE_IE:   sel = SelRiseIe;
            ADDR_FALL_IE:   sel = SelFallIe;
            ADDR_RISE_PEND: sel = SelRisePend;
            ADDR_FALL_PEND: sel = SelFallPend;
            ADDR_ODATA_SET: sel = setclr_en ? SelOdataSet : SelNone;
            ADDR_ODATA_CLR: sel = setclr_en ? SelOdataClr : SelNone;
            ADDR_ODATA_TOG: sel = setclr_en ? SelOdataTog : SelNone;
            ADDR_INFO:      sel = SelInfo;
            default:        sel = SelNone;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: pad-input synchroniser with rise/fall pulse generation. Edge pulses are
// suppressed until the chain has refilled after reset so stale zeros never look like edges.
module pio_sync_edge #(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] idata,
    output logic [WIDTH-1:0] synced,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned MaskCycles = SYNC_STAGES + 1;
    localparam int unsigned CntW       = $clog2(MaskCycles + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [CntW-1:0]  cnt_q;
    logic             armed;

    assign armed  = (cnt_q == CntW'(MaskCycles));
    assign synced = sync_q[SYNC_STAGES-1];
    assign rise   = armed ? (synced & ~prev_q) : '0;
    assign fall   = armed ? (~synced & prev_q) : '0;

    // Synchroniser chain plus one extra sample of its last stage for edge comparison.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= idata;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Post-reset mask: count SYNC_STAGES+1 cycles, then stay armed.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!armed) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/pio_multi.sv
// pio_multi: parametrised programmable I/O with an AXI4-Lite control slave, synchronised
// inputs and per-pin rise/fall interrupts with W1C pending bits.
// Optional feature: define PIO_SETCLR_EN to add the ODATA set/clear/toggle aliases.
module pio_multi
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_ctrl_awvalid,
    output logic             t_ctrl_awready,
    input  logic [31:0]      t_ctrl_awaddr,
    input  logic [2:0]       t_ctrl_awprot,
    input  logic             t_ctrl_wvalid,
    output logic             t_ctrl_wready,
    input  logic [31:0]      t_ctrl_wdata,
    input  logic [3:0]       t_ctrl_wstrb,
    output logic             t_ctrl_bvalid,
    input  logic             t_ctrl_bready,
    output logic [1:0]       t_ctrl_bresp,
    input  logic             t_ctrl_arvalid,
    output logic             t_ctrl_arready,
    input  logic [31:0]      t_ctrl_araddr,
    input  logic [2:0]       t_ctrl_arprot,
    output logic             t_ctrl_rvalid,
    input  logic             t_ctrl_rready,
    output logic [31:0]      t_ctrl_rdata,
    output logic [1:0]       t_ctrl_rresp,
    output logic             irq0,
    output logic             irq1,
    output logic [WIDTH-1:0] odata,
    output logic [WIDTH-1:0] oenable,
    input  logic [WIDTH-1:0] idata
);

`ifdef PIO_SETCLR_EN
    localparam logic SetClrEn = 1'b1;
`else
    localparam logic SetClrEn = 1'b0;
`endif

    logic             aw_held_q, w_held_q, bvalid_q, rvalid_q;
    logic [5:0]       awidx_q;
    logic [WIDTH-1:0] wdata_q;
    logic [3:0]       wstrb_q;
    logic [1:0]       bresp_q, rresp_q;
    logic [31:0]      rdata_q;
    logic [WIDTH-1:0] odata_q, oenable_q, rise_ie_q, fall_ie_q, rise_pend_q, fall_pend_q;
    logic [WIDTH-1:0] odata_d, oenable_d, rise_ie_d, fall_ie_d, rise_pend_d, fall_pend_d;
    logic             irq0_q, irq1_q;

    logic [WIDTH-1:0] synced, rise, fall;
    logic [WIDTH-1:0] wmask, wbits;
    logic [31:0]      rd_val;
    logic [1:0]       rd_resp, wr_resp;
    logic             do_write;
    reg_sel_e         wr_sel, rd_sel;
    logic             unused_bits;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .idata  (idata),
        .synced (synced),
        .rise   (rise),
        .fall   (fall)
    );

    // The write slot stays busy until the response is consumed, so a new AW/W is only
    // taken once the previous B has been accepted.
    assign t_ctrl_awready = !reset && !aw_held_q && !bvalid_q;
    assign t_ctrl_wready  = !reset && !w_held_q && !bvalid_q;
    assign t_ctrl_arready = !reset && !rvalid_q;
    assign t_ctrl_bvalid  = bvalid_q;
    assign t_ctrl_bresp   = bresp_q;
    assign t_ctrl_rvalid  = rvalid_q;
    assign t_ctrl_rdata   = rdata_q;
    assign t_ctrl_rresp   = rresp_q;
    assign odata          = odata_q;
    assign oenable        = oenable_q;
    assign irq0           = irq0_q;
    assign irq1           = irq1_q;

    assign do_write = aw_held_q && w_held_q && !bvalid_q;
    assign wr_sel   = decode_addr(awidx_q, SetClrEn);
    assign rd_sel   = decode_addr(t_ctrl_araddr[7:2], SetClrEn);
    assign wr_resp  = (wr_sel == SelNone) ? RESP_SLVERR : RESP_OKAY;
    assign wbits    = wdata_q & wmask;

    assign unused_bits = ^{t_ctrl_awprot, t_ctrl_arprot, t_ctrl_awaddr, t_ctrl_araddr,
                           t_ctrl_wdata};

    // Expand the held byte strobes to a per-pin write mask.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            wmask[i] = wstrb_q[i/8];
        end
    end

    // Register-file next state; a new edge wins over a coincident W1C.
    always_comb begin
        odata_d     = odata_q;
        oenable_d   = oenable_q;
        rise_ie_d   = rise_ie_q;
        fall_ie_d   = fall_ie_q;
        rise_pend_d = rise_pend_q;
        fall_pend_d = fall_pend_q;
        if (do_write) begin
            case (wr_sel)
                SelOdata:    odata_d     = (odata_q & ~wmask) | wbits;
                SelOenable:  oenable_d   = (oenable_q & ~wmask) | wbits;
                SelRiseIe:   rise_ie_d   = (rise_ie_q & ~wmask) | wbits;
                SelFallIe:   fall_ie_d   = (fall_ie_q & ~wmask) | wbits;
                SelRisePend: rise_pend_d = rise_pend_q & ~wbits;
                SelFallPend: fall_pend_d = fall_pend_q & ~wbits;
`ifdef PIO_SETCLR_EN
                SelOdataSet: odata_d     = odata_q | wbits;
                SelOdataClr: odata_d     = odata_q & ~wbits;
                SelOdataTog: odata_d     = odata_q ^ wbits;
`endif
                default: ;
            endcase
        end
        rise_pend_d = rise_pend_d | (rise & rise_ie_q);
        fall_pend_d = fall_pend_d | (fall & fall_ie_q);
    end

    // Read mux; sampled into rdata on the AR handshake, so it sees pre-write values.
    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            SelOdata:    rd_val[WIDTH-1:0] = odata_q;
            SelOenable:  rd_val[WIDTH-1:0] = oenable_q;
            SelIdata:    rd_val[WIDTH-1:0] = synced;
            SelRiseIe:   rd_val[WIDTH-1:0] = rise_ie_q;
            SelFallIe:   rd_val[WIDTH-1:0] = fall_ie_q;
            SelRisePend: rd_val[WIDTH-1:0] = rise_pend_q;
            SelFallPend: rd_val[WIDTH-1:0] = fall_pend_q;
            SelInfo:     rd_val            = 32'(WIDTH);
            SelOdataSet, SelOdataClr, SelOdataTog: rd_val = '0;
            default:     rd_resp           = RESP_SLVERR;
        endcase
    end

    // AXI-Lite write/read channel state, register file and interrupt flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awidx_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            odata_q     <= '0;
            oenable_q   <= '0;
            rise_ie_q   <= '0;
            fall_ie_q   <= '0;
            rise_pend_q <= '0;
            fall_pend_q <= '0;
            irq0_q      <= 1'b0;
            irq1_q      <= 1'b0;
        end else begin
            if (t_ctrl_awvalid && t_ctrl_awready) begin
                aw_held_q <= 1'b1;
                awidx_q   <= t_ctrl_awaddr[7:2];
            end else if (do_write) begin
                aw_held_q <= 1'b0;
            end

            if (t_ctrl_wvalid && t_ctrl_wready) begin
                w_held_q <= 1'b1;
                wdata_q  <= t_ctrl_wdata[WIDTH-1:0];
                wstrb_q  <= t_ctrl_wstrb;
            end else if (do_write) begin
                w_held_q <= 1'b0;
            end

            if (do_write) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (bvalid_q && t_ctrl_bready) begin
                bvalid_q <= 1'b0;
            end

            if (t_ctrl_arvalid && t_ctrl_arready) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && t_ctrl_rready) begin
                rvalid_q <= 1'b0;
            end

            odata_q     <= odata_d;
            oenable_q   <= oenable_d;
            rise_ie_q   <= rise_ie_d;
            fall_ie_q   <= fall_ie_d;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            irq0_q      <= |rise_pend_q;
            irq1_q      <= |fall_pend_q;
        end
    end

endmodule
